window_streamer: RTL and testbench

Parametrised successor to pixel_loader. Converts a raster pixel stream into WIN x WIN neighbourhood windows for the edge pipeline stages (gaussian, gradient, NMS, hysteresis). Generalises window size, item width and image geometry, and adds:
- valid/ready backpressure on both sides
- explicit start-of-frame resync
- a frame-done pulse

---
 rtl/window_pkg.sv | 18 +
 rtl/line_buffer_ram.sv | 27 ++
 rtl/window_streamer.sv | 174 +++++++++++++++++
 tb/tb_window_streamer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared helpers for the window_streamer slice: safe widths, the window element
// index, and the centre offset of an odd-sized window.
package window_pkg;

  // $clog2 returns 0 for 1, which would give zero-width vectors.
  function automatic int safe_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

  function automatic int center_ofs(input int win);
    return (win - 1) / 2;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One raster row of pixel storage: synchronous write, asynchronous read, so a
// read of the address being written in the same cycle returns the old row.
module line_buffer_ram
  import window_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [safe_clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [safe_clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/window_streamer.sv
// Raster pixel stream to WIN x WIN window stream with valid/ready on both sides,
// start-of-frame resync and a frame-done pulse. Optional WINDOW_STREAMER_COORD_EN
// adds registered window centre coordinates (window_row / window_col).
module window_streamer
  import window_pkg::*;
#(
  parameter int ITEM_SIZE  = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int WIN        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ITEM_SIZE-1:0]              pixel_in,
  input  logic                              pixel_in_valid,
  input  logic                              pixel_in_sof,
  output logic                              pixel_in_ready,
  output logic [WIN*WIN*ITEM_SIZE-1:0]      window_out,
  output logic                              window_out_valid,
  input  logic                              window_out_ready,
  output logic                              frame_done
`ifdef WINDOW_STREAMER_COORD_EN
  ,
  output logic [safe_clog2(IMG_HEIGHT)-1:0] window_row,
  output logic [safe_clog2(IMG_WIDTH)-1:0]  window_col
`endif
);

  // Handshake: a pixel moves when pixel_in_valid && pixel_in_ready; a window
  // moves when window_out_valid && window_out_ready; a held window never changes.
  localparam int CW         = safe_clog2(IMG_WIDTH);
  localparam int RW         = safe_clog2(IMG_HEIGHT);
  localparam int FW         = safe_clog2(WIN);
  localparam int LB_N       = WIN - 1;
  localparam int CENTER_OFS = center_ofs(WIN);
  localparam int WW         = WIN * WIN * ITEM_SIZE;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_EMIT  = CW'(WIN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIN - 1);

  typedef logic [ITEM_SIZE-1:0] item_t;

  logic [CW-1:0] col_q, eff_col;
  logic [RW-1:0] row_q, eff_row;
  logic [FW-1:0] fill_q, eff_fill;
  logic          accept, emit, last_pixel;

  item_t         lb_rd   [LB_N];
  item_t         lb_wd   [LB_N];
  item_t         new_col [WIN];
  item_t         win_q   [WIN][WIN];
  item_t         win_d   [WIN][WIN];
  logic [WW-1:0] win_flat;

  assign pixel_in_ready = !window_out_valid || window_out_ready;
  assign accept         = pixel_in_valid && pixel_in_ready;

  // sof re-addresses the pixel it qualifies as (0,0) with no fresh rows stored.
  always_comb begin
    eff_col    = pixel_in_sof ? '0 : col_q;
    eff_row    = pixel_in_sof ? '0 : row_q;
    eff_fill   = pixel_in_sof ? '0 : fill_q;
    emit       = (eff_fill == FILL_FULL) && (eff_col >= COL_EMIT);
    last_pixel = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      if (eff_col == COL_LAST) begin
        col_q <= '0;
        if (eff_row == ROW_LAST) begin
          row_q  <= '0;
          fill_q <= '0;
        end else begin
          row_q  <= eff_row + 1'b1;
          fill_q <= (eff_fill == FILL_FULL) ? eff_fill : eff_fill + 1'b1;
        end
      end else begin
        col_q  <= eff_col + 1'b1;
        row_q  <= eff_row;
        fill_q <= eff_fill;
      end
    end
  end

  // Line buffers form a chain: buffer k holds row-(k+1) at each column.
  always_comb begin
    lb_wd[0] = pixel_in;
    for (int k = 1; k < LB_N; k++) begin
      lb_wd[k] = lb_rd[k-1];
    end
  end

  for (genvar g = 0; g < LB_N; g++) begin : g_lb
    line_buffer_ram #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (ITEM_SIZE)
    ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (eff_col),
      .wdata (lb_wd[g]),
      .raddr (eff_col),
      .rdata (lb_rd[g])
    );
  end

  // Row 0 of a window is the oldest row, column 0 the oldest column.
  always_comb begin
    new_col[WIN-1] = pixel_in;
    for (int r = 0; r < WIN - 1; r++) begin
      new_col[r] = lb_rd[WIN-2-r];
    end
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][WIN-1] = new_col[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_flat[idx(r, c, WIN)*ITEM_SIZE +: ITEM_SIZE] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Only one output slot: a new window loads only when the old one is leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_out       <= '0;
      window_out_valid <= 1'b0;
      frame_done       <= 1'b0;
`ifdef WINDOW_STREAMER_COORD_EN
      window_row       <= '0;
      window_col       <= '0;
`endif
    end else begin
      frame_done <= accept && last_pixel;
      if (accept && emit) begin
        window_out       <= win_flat;
        window_out_valid <= 1'b1;
`ifdef WINDOW_STREAMER_COORD_EN
        window_row       <= eff_row - RW'(CENTER_OFS);
        window_col       <= eff_col - CW'(CENTER_OFS);
`endif
      end else if (window_out_ready) begin
        window_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_streamer.sv
// Scoreboard bench for window_streamer on an 8x6 image with 3x3 windows; pixel
// value is row*8+col (plus a per-frame offset for the abandoned frame).
module tb_window_streamer;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int WN   = 3;
  localparam int IS   = 8;
  localparam int HALF = 5;
  localparam int WW   = WN * WN * IS;
  localparam int EW   = WW + 6;

  localparam logic [WW-1:0] FIRST_WIN = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [WW-1:0] LAST_WIN  = {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29};

  logic          clk = 1'b0;
  logic          rst;
  logic [IS-1:0] pixel_in;
  logic          pixel_in_valid;
  logic          pixel_in_sof;
  logic          pixel_in_ready;
  logic [WW-1:0] window_out;
  logic          window_out_valid;
  logic          window_out_ready;
  logic          frame_done;
`ifdef WINDOW_STREAMER_COORD_EN
  logic [2:0]    window_row;
  logic [2:0]    window_col;
`endif

  always #HALF clk = ~clk;

  window_streamer #(
    .ITEM_SIZE (IS),
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .WIN       (WN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_in_sof    (pixel_in_sof),
    .pixel_in_ready  (pixel_in_ready),
    .window_out      (window_out),
    .window_out_valid(window_out_valid),
    .window_out_ready(window_out_ready),
    .frame_done      (frame_done)
`ifdef WINDOW_STREAMER_COORD_EN
    ,
    .window_row      (window_row),
    .window_col      (window_col)
`endif
  );

  // Scoreboard entry: {window, centre row, centre col}.
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          fd_mark = 1'b0;
  bit            mon_en = 1'b0;
  int            n_win = 0;
  int            n_fd = 0;
  logic [WW-1:0] first_win, last_win, fd_win;
  time           first_t, acc_t;
  bit            first_seen = 1'b0;
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [IS-1:0] pix(input int r, input int c, input int base);
    return IS'(r * 8 + c + base);
  endfunction

  function automatic logic [WW-1:0] exp_window(input int r, input int c, input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int rr = 0; rr < WN; rr++) begin
      for (int cc = 0; cc < WN; cc++) begin
        w[(rr*WN+cc)*IS +: IS] = pix(r - 2 + rr, c - 2 + cc, base);
      end
    end
    return w;
  endfunction

  // Monitor: pops on every output transfer, tracks frame_done against the driver's mark.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (window_out_valid && window_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window actual=%0h required=none", window_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("window", window_out, mon_e[EW-1:6]);
`ifdef WINDOW_STREAMER_COORD_EN
          check("window_row", WW'(window_row), WW'(mon_e[5:3]));
          check("window_col", WW'(window_col), WW'(mon_e[2:0]));
`endif
          n_win++;
          last_win = window_out;
        end
      end
      if (frame_done || fd_mark) check("frame_done", WW'(frame_done), WW'(fd_mark));
      if (frame_done) begin
        n_fd++;
        fd_win = window_out;
        check("fd_with_valid", WW'(window_out_valid), WW'(1));
      end
      fd_mark = 1'b0;
      if (window_out_valid && !first_seen) begin
        first_seen = 1'b1;
        first_t    = $time;
        first_win  = window_out;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [IS-1:0] v, input logic sof, input bit emit_exp,
                      input logic [EW-1:0] e, input bit last, input bit bubbles);
    int   n = 0;
    logic rdy;
    while (bubbles && n < 4 && $urandom_range(0, 1) == 1) begin
      pixel_in_valid = 1'b0;
      pixel_in       = IS'($urandom);
      pixel_in_sof   = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    pixel_in       = v;
    pixel_in_sof   = sof;
    pixel_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = pixel_in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_ready required=accepted");
    end else begin
      acc_t = $time;
      if (emit_exp) exp_q.push_back(e);
      fd_mark = last;
    end
    #1;
    pixel_in_valid = 1'b0;
    pixel_in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit bubbles, input int stop_r,
                            input int stop_c, output time t22);
    logic [EW-1:0] e;
    t22 = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        e = {exp_window(r, c, base), 3'(r - 1), 3'(c - 1)};
        send(pix(r, c, base), (r == 0 && c == 0), (r >= 2 && c >= 2), e,
             (r == IH - 1 && c == IW - 1), bubbles);
        if (r == 2 && c == 2) t22 = acc_t;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || window_out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, WW'(exp_q.size()), WW'(0));
  endtask

  task automatic bp_ctrl();
    int n = 0;
    while (!window_out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!window_out_valid) begin
      checks++;
      errors++;
      $display("FAIL bp_wait actual=no_window required=window");
    end else begin
      window_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_in_ready", WW'(pixel_in_ready), WW'(0));
        check("bp_hold", window_out, FIRST_WIN);
        check("bp_valid", WW'(window_out_valid), WW'(1));
      end
      @(posedge clk);
      #1;
      window_out_ready = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bw, bf;
    time t22;
    rst = 1'b1;
    pixel_in = '0;
    pixel_in_valid = 1'b0;
    pixel_in_sof = 1'b0;
    window_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", WW'(window_out_valid), WW'(0));
    check("rst_window", window_out, WW'(0));
    check("rst_fd", WW'(frame_done), WW'(0));
    check("rst_in_ready", WW'(pixel_in_ready), WW'(1));
`ifdef WINDOW_STREAMER_COORD_EN
    check("rst_row", WW'(window_row), WW'(0));
    check("rst_col", WW'(window_col), WW'(0));
`endif
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, no stalls.
    bw = n_win; bf = n_fd; first_seen = 1'b0;
    send_frame(0, 1'b0, -1, -1, t22);
    drain("s1_drain");
    check("s1_latency", WW'(first_t - t22), WW'(HALF));
    check("s1_first", first_win, FIRST_WIN);
    check("s1_last", last_win, LAST_WIN);
    check("s1_fd_win", fd_win, LAST_WIN);
    check("s1_count", WW'(n_win - bw), WW'(24));
    check("s1_fd_count", WW'(n_fd - bf), WW'(1));

    // Output backpressure after the first window.
    bw = n_win; bf = n_fd;
    fork
      send_frame(0, 1'b0, -1, -1, t22);
      bp_ctrl();
    join
    drain("s2_drain");
    check("s2_count", WW'(n_win - bw), WW'(24));
    check("s2_fd_count", WW'(n_fd - bf), WW'(1));

    // Random input bubbles.
    bw = n_win; bf = n_fd;
    send_frame(0, 1'b1, -1, -1, t22);
    drain("s3_drain");
    check("s3_count", WW'(n_win - bw), WW'(24));
    check("s3_fd_count", WW'(n_fd - bf), WW'(1));

    // Abandon a frame at (3,4), then a full fresh frame.
    bw = n_win; bf = n_fd;
    send_frame(128, 1'b0, 3, 4, t22);
    drain("s4a_drain");
    check("s4a_count", WW'(n_win - bw), WW'(8));
    check("s4a_fd_count", WW'(n_fd - bf), WW'(0));
    bw = n_win; bf = n_fd; first_seen = 1'b0;
    send_frame(0, 1'b0, -1, -1, t22);
    drain("s4b_drain");
    check("s4b_latency", WW'(first_t - t22), WW'(HALF));
    check("s4b_first", first_win, FIRST_WIN);
    check("s4b_count", WW'(n_win - bw), WW'(24));
    check("s4b_fd_count", WW'(n_fd - bf), WW'(1));

    // Reset with a window pending, then a full frame.
    send_frame(0, 1'b0, 3, 0, t22);
    check("s5_valid_before", WW'(window_out_valid), WW'(1));
    rst = 1'b1;
    #1;
    check("s5_rst_valid", WW'(window_out_valid), WW'(0));
    check("s5_rst_window", window_out, WW'(0));
    check("s5_rst_fd", WW'(frame_done), WW'(0));
    exp_q.delete();
    fd_mark = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bw = n_win; bf = n_fd; first_seen = 1'b0;
    send_frame(0, 1'b0, -1, -1, t22);
    drain("s5_drain");
    check("s5_first", first_win, FIRST_WIN);
    check("s5_last", last_win, LAST_WIN);
    check("s5_count", WW'(n_win - bw), WW'(24));
    check("s5_fd_count", WW'(n_fd - bf), WW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
